// File: rtl/filter_mode_scheduler.sv
// Filter depth scheduler: picks bypass/LOW/MID/HIGH from the tempo estimate with
// hysteresis, switches only at frame boundaries, and rate-limits beat triggers.
module filter_mode_scheduler #(
  parameter int unsigned LOW_BPM      = 100,
  parameter int unsigned HIGH_BPM     = 140,
  parameter int unsigned HYST         = 4,
  parameter int unsigned MIN_BEAT_GAP = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        filter_enable,
  input  logic [15:0] bpm_estimate,
  input  logic        bpm_valid,
  input  logic        beat_detected,
  input  logic        frame_start,
  input  logic        anim_busy,
  output logic [1:0]  stage_sel,
  output logic        beat_trigger,
  output logic        mode_changed,
  output logic [7:0]  beats_dropped
);

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    LOW    = 2'd1,
    MID    = 2'd2,
    HIGH   = 2'd3
  } mode_t;

  localparam logic [16:0] LO_TH   = 17'(LOW_BPM);
  localparam logic [16:0] HI_TH   = 17'(HIGH_BPM);
  localparam logic [16:0] LO_UP   = 17'(LOW_BPM + HYST);
  localparam logic [16:0] LO_DN   = 17'(LOW_BPM - HYST);
  localparam logic [16:0] HI_UP   = 17'(HIGH_BPM + HYST);
  localparam logic [16:0] HI_DN   = 17'(HIGH_BPM - HYST);
  localparam logic [15:0] GAP_LD  = 16'(MIN_BEAT_GAP);

  mode_t       state;
  mode_t       target;
  logic [15:0] bpm_q;
  logic [15:0] gap_cnt;
  logic        pending;
  logic [16:0] bpm_x;
  logic        eligible;
  logic        drop_beat;

  assign stage_sel = state;
  assign bpm_x     = {1'b0, bpm_q};

  always_comb begin
    target = state;
    if (!filter_enable) begin
      target = BYPASS;
    end else begin
      unique case (state)
        BYPASS: target = (bpm_x < LO_TH) ? LOW : (bpm_x < HI_TH) ? MID : HIGH;
        LOW:    target = (bpm_x >= HI_UP) ? HIGH : (bpm_x >= LO_UP) ? MID : LOW;
        MID:    target = (bpm_x < LO_DN) ? LOW : (bpm_x >= HI_UP) ? HIGH : MID;
        HIGH:   target = (bpm_x < LO_DN) ? LOW : (bpm_x < HI_DN) ? MID : HIGH;
        default: target = BYPASS;
      endcase
    end
  end

  // A pending beat in HIGH is consumed by the issuing trigger rather than dropped.
  assign eligible  = (beat_detected || pending) && (state == MID || state == HIGH)
                     && !anim_busy && (gap_cnt == '0);
  assign drop_beat = beat_detected && !eligible
                     && ((state == MID) || (state == HIGH && pending));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BYPASS;
      bpm_q         <= '0;
      gap_cnt       <= '0;
      pending       <= 1'b0;
      beat_trigger  <= 1'b0;
      mode_changed  <= 1'b0;
      beats_dropped <= '0;
    end else begin
      if (bpm_valid) bpm_q <= bpm_estimate;

      mode_changed <= 1'b0;
      if (frame_start) begin
        state        <= target;
        mode_changed <= (target != state);
      end

      beat_trigger <= eligible;
      if (eligible)            gap_cnt <= GAP_LD;
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 16'd1;

      if (frame_start && target != state)                 pending <= 1'b0;
      else if (eligible)                                  pending <= 1'b0;
      else if (beat_detected && state == HIGH && !pending) pending <= 1'b1;

      if (drop_beat && beats_dropped != '1) beats_dropped <= beats_dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_filter_mode_scheduler.sv
// Directed bench for filter_mode_scheduler: mode table plus beat/reset sequences.
module tb_filter_mode_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        filter_enable;
  logic [15:0] bpm_estimate;
  logic        bpm_valid;
  logic        beat_detected;
  logic        frame_start;
  logic        anim_busy;
  logic [1:0]  stage_sel;
  logic        beat_trigger;
  logic        mode_changed;
  logic [7:0]  beats_dropped;

  int checks = 0;
  int errors = 0;

  filter_mode_scheduler #(
    .LOW_BPM(100), .HIGH_BPM(140), .HYST(4), .MIN_BEAT_GAP(1000)
  ) dut (
    .clk(clk), .reset(reset), .filter_enable(filter_enable),
    .bpm_estimate(bpm_estimate), .bpm_valid(bpm_valid),
    .beat_detected(beat_detected), .frame_start(frame_start),
    .anim_busy(anim_busy), .stage_sel(stage_sel), .beat_trigger(beat_trigger),
    .mode_changed(mode_changed), .beats_dropped(beats_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] bpm;
    logic [1:0]  exp_stage;
    logic        exp_changed;
  } vec_t;

  vec_t vecs[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_stage", stage_sel, 0);
    check("rst_trigger", beat_trigger, 0);
    check("rst_changed", mode_changed, 0);
    check("rst_dropped", beats_dropped, 0);
  endtask

  // Load a new estimate, then present a frame boundary in the following cycle.
  task automatic apply_mode(input logic en, input logic [15:0] bpm);
    filter_enable = en;
    bpm_estimate  = bpm;
    bpm_valid     = 1'b1;
    step();
    bpm_valid   = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    int first_k;
    int trig_cnt;

    reset = 1'b0; filter_enable = 1'b1; bpm_estimate = '0; bpm_valid = 1'b0;
    beat_detected = 1'b0; frame_start = 1'b0; anim_busy = 1'b0;

    vecs[0]  = '{1'b1, 16'd120,   2'd2, 1'b1};
    vecs[1]  = '{1'b1, 16'd138,   2'd2, 1'b0};
    vecs[2]  = '{1'b1, 16'd144,   2'd3, 1'b1};
    vecs[3]  = '{1'b1, 16'd137,   2'd3, 1'b0};
    vecs[4]  = '{1'b1, 16'd135,   2'd2, 1'b1};
    vecs[5]  = '{1'b1, 16'd97,    2'd2, 1'b0};
    vecs[6]  = '{1'b1, 16'd95,    2'd1, 1'b1};
    vecs[7]  = '{1'b1, 16'd103,   2'd1, 1'b0};
    vecs[8]  = '{1'b1, 16'd104,   2'd2, 1'b1};
    vecs[9]  = '{1'b0, 16'd150,   2'd0, 1'b1};
    vecs[10] = '{1'b1, 16'd150,   2'd3, 1'b1};
    vecs[11] = '{1'b1, 16'd60,    2'd1, 1'b1};
    vecs[12] = '{1'b1, 16'd200,   2'd3, 1'b1};
    vecs[13] = '{1'b1, 16'd65535, 2'd3, 1'b0};
    vecs[14] = '{1'b0, 16'd65535, 2'd0, 1'b1};

    step();
    do_reset();

    for (int i = 0; i < 15; i++) begin
      apply_mode(vecs[i].en, vecs[i].bpm);
      check($sformatf("vec%0d_stage", i), stage_sel, vecs[i].exp_stage);
      check($sformatf("vec%0d_changed", i), mode_changed, vecs[i].exp_changed);
      step();
      check($sformatf("vec%0d_changed_1cy", i), mode_changed, 0);
    end

    // Mid-frame estimate change waits for the next frame boundary.
    do_reset();
    apply_mode(1'b1, 16'd120);
    check("mid_enter", stage_sel, 2);
    bpm_estimate = 16'd150; bpm_valid = 1'b1;
    step();
    bpm_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("midframe_hold", stage_sel, 2);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("midframe_to_high", stage_sel, 3);
    filter_enable = 1'b0; frame_start = 1'b1;
    step();
    frame_start = 1'b0; filter_enable = 1'b1;
    check("disable_bypass", stage_sel, 0);
    // Simultaneous estimate and frame boundary: decision uses old estimate (150).
    bpm_estimate = 16'd60; bpm_valid = 1'b1; frame_start = 1'b1;
    step();
    bpm_valid = 1'b0; frame_start = 1'b0;
    check("same_cycle_old_bpm", stage_sel, 3);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("same_cycle_new_bpm", stage_sel, 1);

    // LOW ignores beats entirely.
    trig_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      beat_detected = 1'b1;
      step();
      beat_detected = 1'b0;
      step();
      if (beat_trigger) trig_cnt++;
    end
    check("low_no_trigger", trig_cnt, 0);
    check("low_no_drop", beats_dropped, 0);

    // HIGH: first beat, pending second beat, third beat dropped.
    apply_mode(1'b1, 16'd150);
    check("beat_high", stage_sel, 3);
    for (int i = 0; i < 5; i++) step();
    beat_detected = 1'b1;
    step();
    beat_detected = 1'b0;
    check("beat_first_trigger", beat_trigger, 1);
    first_k = -1;
    trig_cnt = 0;
    for (int k = 2; k <= 1100; k++) begin
      beat_detected = (k == 11 || k == 20);
      step();
      if (beat_trigger) begin
        trig_cnt++;
        if (first_k < 0) first_k = k;
      end
    end
    beat_detected = 1'b0;
    check("pending_trigger_edge", first_k, 1002);
    check("pending_trigger_count", trig_cnt, 1);
    check("pending_drop", beats_dropped, 1);

    // MID with busy animation drops beats and saturates.
    do_reset();
    apply_mode(1'b1, 16'd120);
    anim_busy = 1'b1;
    beat_detected = 1'b1;
    step();
    beat_detected = 1'b0;
    check("mid_busy_drop1", beats_dropped, 1);
    step();
    check("mid_busy_no_trigger", beat_trigger, 0);
    trig_cnt = 0;
    for (int i = 0; i < 299; i++) begin
      beat_detected = 1'b1;
      step();
      if (beat_trigger) trig_cnt++;
    end
    beat_detected = 1'b0;
    anim_busy = 1'b0;
    step();
    check("mid_busy_sat", beats_dropped, 255);
    check("mid_busy_triggers", trig_cnt, 0);

    // Reset while a beat is pending in HIGH.
    do_reset();
    apply_mode(1'b1, 16'd150);
    beat_detected = 1'b1;
    step();
    beat_detected = 1'b0;
    check("rstpend_trigger", beat_trigger, 1);
    for (int i = 0; i < 3; i++) step();
    beat_detected = 1'b1;
    step();
    beat_detected = 1'b0;
    do_reset();
    trig_cnt = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (beat_trigger) trig_cnt++;
    end
    check("rstpend_no_trigger", trig_cnt, 0);
    check("rstpend_stage", stage_sel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
